fp_mul_pipe: RTL and testbench

Parametrised, pipelined IEEE-754-style binary floating-point multiplier. It generalises the team's combinational fp16 multiplier to any exponent/mantissa width (fp16, bf16, fp32), and adds:
- four rounding modes,
- exception flags,
- a 3-stage registered datapath with valid/ready flow control.

It sits between operand-issue logic and result writeback in the FP datapath.

---
 rtl/fp_mul_pipe.sv | 234 +++++++++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: parameterised 3-stage binary floating-point multiplier.
//   Stage 1 unpacks the operands, classifies them and resolves special
//   cases; stage 2 forms the significand product; stage 3 normalises,
//   rounds and packs the result. The whole pipe advances together
//   (adv = !o_valid | i_ready), so bubbles are kept rather than squeezed
//   out.
//
// Ports:
//   i_clk, i_rst_n    clock, synchronous active-low reset
//   i_valid, o_ready  operand handshake (o_ready = adv)
//   i_a, i_b          operands {sign, exp[EW], mant[MW]}
//   i_rm              rounding mode: 0 RNE, 1 RTZ, 2 RUP, 3 RDN
//   o_valid, i_ready  result handshake
//   o_res, o_flags    product and {NV, OF, UF, NX}, qualified by o_valid
module fp_mul_pipe #(
  parameter int EW = 5,
  parameter int MW = 10,
  parameter int W  = 1 + EW + MW
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [1:0]   i_rm,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_res,
  output logic [3:0]   o_flags
);

  // Exponents are carried as EW+2-bit two's complement so that the biased
  // sum, the normalisation step and the rounding carry never wrap.
  localparam int XW = EW + 2;
  localparam int PW = 2 * MW + 2;

  localparam logic [XW-1:0] BIAS     = XW'((1 << (EW - 1)) - 1);
  localparam logic [XW-1:0] EXP_INF  = XW'((1 << EW) - 1);
  localparam logic [EW-1:0] EXP_ONES = {EW{1'b1}};
  localparam logic [EW-1:0] EXP_MAXF = {{(EW - 1){1'b1}}, 1'b0};
  localparam logic [W-1:0]  QNAN     = {1'b0, EXP_ONES, 1'b1, {(MW - 1){1'b0}}};

  localparam logic [1:0] RM_RNE = 2'd0;
  localparam logic [1:0] RM_RTZ = 2'd1;
  localparam logic [1:0] RM_RUP = 2'd2;
  localparam logic [1:0] RM_RDN = 2'd3;

  logic          adv;

  logic          s1_valid_q;
  logic          s1_sign_q,  s1_sign_d;
  logic [XW-1:0] s1_exp_q,   s1_exp_d;
  logic [MW:0]   s1_ma_q,    s1_mb_q;
  logic          s1_spec_q,  s1_spec_d;
  logic [W-1:0]  s1_sres_q,  s1_sres_d;
  logic [3:0]    s1_sflg_q,  s1_sflg_d;
  logic [1:0]    s1_rm_q;

  logic          s2_valid_q;
  logic          s2_sign_q;
  logic [XW-1:0] s2_exp_q;
  logic [PW-1:0] s2_prod_q,  s2_prod_d;
  logic          s2_spec_q;
  logic [W-1:0]  s2_sres_q;
  logic [3:0]    s2_sflg_q;
  logic [1:0]    s2_rm_q;

  logic          o_valid_q;
  logic [W-1:0]  o_res_q,    o_res_d;
  logic [3:0]    o_flags_q,  o_flags_d;

  assign adv     = ~o_valid_q | i_ready;
  assign o_ready = adv;
  assign o_valid = o_valid_q;
  assign o_res   = o_res_q;
  assign o_flags = o_flags_q;

  // ---------------- stage 1: unpack and classify ----------------
  logic          sa, sb;
  logic [EW-1:0] ea, eb;
  logic [MW-1:0] ma, mb;
  logic          a_zero, a_inf, a_nan, a_snan;
  logic          b_zero, b_inf, b_nan, b_snan;
  logic          inv_op;

  assign sa = i_a[W-1];
  assign sb = i_b[W-1];
  assign ea = i_a[W-2:MW];
  assign eb = i_b[W-2:MW];
  // Subnormal inputs are treated as zero.
  assign ma = (ea == '0) ? '0 : i_a[MW-1:0];
  assign mb = (eb == '0) ? '0 : i_b[MW-1:0];

  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == EXP_ONES) & ~|ma;
  assign b_inf  = (eb == EXP_ONES) & ~|mb;
  assign a_nan  = (ea == EXP_ONES) & |ma;
  assign b_nan  = (eb == EXP_ONES) & |mb;
  assign a_snan = a_nan & ~ma[MW-1];
  assign b_snan = b_nan & ~mb[MW-1];
  assign inv_op = (a_inf & b_zero) | (a_zero & b_inf);

  assign s1_sign_d = sa ^ sb;
  assign s1_exp_d  = {2'b00, ea} + {2'b00, eb} - BIAS;

  always_comb begin
    s1_spec_d = 1'b1;
    s1_sres_d = QNAN;
    s1_sflg_d = 4'b0000;
    if (a_nan | b_nan | inv_op) begin
      s1_sflg_d = {inv_op | a_snan | b_snan, 3'b000};
    end else if (a_inf | b_inf) begin
      s1_sres_d = {s1_sign_d, EXP_ONES, {MW{1'b0}}};
    end else if (a_zero | b_zero) begin
      s1_sres_d = {s1_sign_d, {(W - 1){1'b0}}};
    end else begin
      s1_spec_d = 1'b0;
    end
  end

  // ---------------- stage 2: significand product ----------------
  assign s2_prod_d = {{(MW + 1){1'b0}}, s1_ma_q} * {{(MW + 1){1'b0}}, s1_mb_q};

  // ---------------- stage 3: normalise, round, pack ----------------
  logic          msb;
  logic [PW-1:0] norm;
  logic [MW:0]   sig;
  logic          bit_l, bit_g, bit_r, bit_s;
  logic          inc, inexact, carry;
  logic [MW+1:0] sig_r;
  logic [MW-1:0] mant_r;
  logic [XW-1:0] exp_n, exp_r;
  logic          ovf, unf;
  logic [W-1:0]  inf_res, max_res;

  assign msb   = s2_prod_q[PW-1];
  // Aligning to the product MSB keeps the dropped LSB inside the sticky
  // field, so both cases share one L/G/R/S extraction.
  assign norm  = msb ? s2_prod_q : {s2_prod_q[PW-2:0], 1'b0};
  assign sig   = norm[PW-1:MW+1];
  assign bit_l = norm[MW+1];
  assign bit_g = norm[MW];
  assign bit_r = norm[MW-1];
  assign bit_s = |norm[MW-2:0];
  assign exp_n = s2_exp_q + {{(XW - 1){1'b0}}, msb};
  assign inexact = bit_g | bit_r | bit_s;

  always_comb begin
    inc = 1'b0;
    case (s2_rm_q)
      RM_RNE: inc = bit_g & (bit_r | bit_s | bit_l);
      RM_RTZ: inc = 1'b0;
      RM_RUP: inc = ~s2_sign_q & inexact;
      RM_RDN: inc = s2_sign_q & inexact;
      default: inc = 1'b0;
    endcase
  end

  assign sig_r  = {1'b0, sig} + {{(MW + 1){1'b0}}, inc};
  assign carry  = sig_r[MW+1];
  assign mant_r = carry ? sig_r[MW:1] : sig_r[MW-1:0];
  assign exp_r  = exp_n + {{(XW - 1){1'b0}}, carry};

  assign ovf = ~exp_r[XW-1] & (exp_r >= EXP_INF);
  assign unf = exp_r[XW-1] | (exp_r == '0);

  assign inf_res = {s2_sign_q, EXP_ONES, {MW{1'b0}}};
  assign max_res = {s2_sign_q, EXP_MAXF, {MW{1'b1}}};

  always_comb begin
    o_res_d   = {s2_sign_q, exp_r[EW-1:0], mant_r};
    o_flags_d = {3'b000, inexact};
    if (s2_spec_q) begin
      o_res_d   = s2_sres_q;
      o_flags_d = s2_sflg_q;
    end else if (ovf) begin
      o_flags_d = 4'b0101;
      case (s2_rm_q)
        RM_RNE: o_res_d = inf_res;
        RM_RTZ: o_res_d = max_res;
        RM_RUP: o_res_d = s2_sign_q ? max_res : inf_res;
        RM_RDN: o_res_d = s2_sign_q ? inf_res : max_res;
        default: o_res_d = inf_res;
      endcase
    end else if (unf) begin
      o_res_d   = {s2_sign_q, {(W - 1){1'b0}}};
      o_flags_d = 4'b0011;
    end
  end

  // ---------------- registers ----------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      o_valid_q  <= 1'b0;
      o_res_q    <= '0;
      o_flags_q  <= '0;
    end else if (adv) begin
      s1_valid_q <= i_valid;
      s2_valid_q <= s1_valid_q;
      o_valid_q  <= s2_valid_q;
      if (s2_valid_q) begin
        o_res_q   <= o_res_d;
        o_flags_q <= o_flags_d;
      end
    end
  end

  // Payload registers only need to follow the valid bits, so no reset.
  always_ff @(posedge i_clk) begin
    if (adv) begin
      s1_sign_q <= s1_sign_d;
      s1_exp_q  <= s1_exp_d;
      s1_ma_q   <= {1'b1, ma};
      s1_mb_q   <= {1'b1, mb};
      s1_spec_q <= s1_spec_d;
      s1_sres_q <= s1_sres_d;
      s1_sflg_q <= s1_sflg_d;
      s1_rm_q   <= i_rm;

      s2_sign_q <= s1_sign_q;
      s2_exp_q  <= s1_exp_q;
      s2_prod_q <= s2_prod_d;
      s2_spec_q <= s1_spec_q;
      s2_sres_q <= s1_sres_q;
      s2_sflg_q <= s1_sflg_q;
      s2_rm_q   <= s1_rm_q;
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
module tb_fp_mul_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // fp16 instance (h_*) and bf16 instance (g_*)
  logic        h_ivalid, h_oready, h_ovalid, h_iready;
  logic [15:0] h_a, h_b, h_res;
  logic [1:0]  h_rm;
  logic [3:0]  h_flags;

  logic        g_ivalid, g_oready, g_ovalid, g_iready;
  logic [15:0] g_a, g_b, g_res;
  logic [1:0]  g_rm;
  logic [3:0]  g_flags;

  int checks = 0;
  int errors = 0;
  int n_out_h = 0;
  int n_out_g = 0;
  logic [19:0] q_h[$];
  logic [19:0] q_g[$];

  fp_mul_pipe #(.EW(5), .MW(10)) u_h (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(h_ivalid), .o_ready(h_oready),
    .i_a(h_a), .i_b(h_b), .i_rm(h_rm), .o_valid(h_ovalid), .i_ready(h_iready),
    .o_res(h_res), .o_flags(h_flags)
  );

  fp_mul_pipe #(.EW(8), .MW(7)) u_g (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(g_ivalid), .o_ready(g_oready),
    .i_a(g_a), .i_b(g_b), .i_rm(g_rm), .o_valid(g_ovalid), .i_ready(g_iready),
    .o_res(g_res), .o_flags(g_flags)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer significand product, then quotient/remainder
  // rounding. Returns {flags, result}.
  function automatic logic [19:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                          input int ew, input int mw, input logic [1:0] rm);
    longint one, mmask, emask, ma, mb, sig, q, rem, half, sv, inf_p, max_p, r;
    int ea, eb, e, bias, sh;
    logic s, az, bz, ai, bi, an, bn, asn, bsn, inc;
    logic [3:0] fl;
    one   = 1;
    mmask = (one << mw) - 1;
    emask = (one << ew) - 1;
    bias  = (1 << (ew - 1)) - 1;
    s  = a[ew+mw] ^ b[ew+mw];
    ea = int'((longint'(a) >> mw) & emask);
    eb = int'((longint'(b) >> mw) & emask);
    ma = longint'(a) & mmask;
    mb = longint'(b) & mmask;
    az = (ea == 0);
    bz = (eb == 0);
    ai = (ea == emask) && (ma == 0);
    bi = (eb == emask) && (mb == 0);
    an = (ea == emask) && (ma != 0);
    bn = (eb == emask) && (mb != 0);
    asn = an && (((ma >> (mw - 1)) & 1) == 0);
    bsn = bn && (((mb >> (mw - 1)) & 1) == 0);
    sv    = s ? (one << (ew + mw)) : 0;
    inf_p = sv | (emask << mw);
    max_p = sv | ((emask - 1) << mw) | mmask;
    fl = 4'b0000;
    if (an || bn || (ai && bz) || (az && bi)) begin
      r  = (emask << mw) | (one << (mw - 1));
      fl = {((ai && bz) || (az && bi) || asn || bsn), 3'b000};
    end else if (ai || bi) begin
      r = inf_p;
    end else if (az || bz) begin
      r = sv;
    end else begin
      sig = ((one << mw) | ma) * ((one << mw) | mb);
      e   = ea + eb - bias;
      if (sig >= (one << (2 * mw + 1))) begin
        sh = mw + 1;
        e++;
      end else begin
        sh = mw;
      end
      q    = sig >> sh;
      rem  = sig & ((one << sh) - 1);
      half = one << (sh - 1);
      case (rm)
        2'd0:    inc = (rem > half) || ((rem == half) && ((q & 1) == 1));
        2'd1:    inc = 1'b0;
        2'd2:    inc = !s && (rem != 0);
        default: inc = s && (rem != 0);
      endcase
      q = q + longint'(inc);
      if (q == (one << (mw + 1))) begin
        q = q >> 1;
        e++;
      end
      if (e >= emask) begin
        fl = 4'b0101;
        case (rm)
          2'd0:    r = inf_p;
          2'd1:    r = max_p;
          2'd2:    r = s ? max_p : inf_p;
          default: r = s ? inf_p : max_p;
        endcase
      end else if (e <= 0) begin
        r  = sv;
        fl = 4'b0011;
      end else begin
        r  = sv | (longint'(e) << mw) | (q & mmask);
        fl = {3'b000, (rem != 0)};
      end
    end
    return {fl, 16'(r)};
  endfunction

  function automatic logic [15:0] rand_op(input int ew, input int mw);
    longint one, e, m, s;
    int bias, pick;
    one  = 1;
    bias = (1 << (ew - 1)) - 1;
    pick = int'($urandom_range(0, 15));
    s = longint'($urandom_range(0, 1));
    m = longint'($urandom) & ((one << mw) - 1);
    if (pick == 0)      e = 0;
    else if (pick == 1) e = (one << ew) - 1;
    else if (pick < 9)  e = longint'(bias - 4) + longint'($urandom_range(0, 8));
    else                e = longint'($urandom_range(1, (1 << ew) - 2));
    return 16'((s << (ew + mw)) | (e << mw) | m);
  endfunction

  // Scoreboards: predict on accept, compare on output transfer.
  always @(negedge clk) begin
    logic [19:0] ex;
    if (!rst_n) begin
      q_h.delete();
    end else begin
      if (h_ovalid && h_iready) begin
        checks++;
        assert (q_h.size() != 0) else begin
          errors++;
          $error("FAIL fp16 spurious result observed=%h expected=none", h_res);
        end
        if (q_h.size() != 0) begin
          ex = q_h.pop_front();
          chk("fp16 res", 32'(h_res), 32'(ex[15:0]));
          chk("fp16 flags", 32'(h_flags), 32'(ex[19:16]));
        end
        n_out_h++;
      end
      if (h_ivalid && h_oready) q_h.push_back(ref_mul(h_a, h_b, 5, 10, h_rm));
    end
  end

  always @(negedge clk) begin
    logic [19:0] ex;
    if (!rst_n) begin
      q_g.delete();
    end else begin
      if (g_ovalid && g_iready) begin
        checks++;
        assert (q_g.size() != 0) else begin
          errors++;
          $error("FAIL bf16 spurious result observed=%h expected=none", g_res);
        end
        if (q_g.size() != 0) begin
          ex = q_g.pop_front();
          chk("bf16 res", 32'(g_res), 32'(ex[15:0]));
          chk("bf16 flags", 32'(g_flags), 32'(ex[19:16]));
        end
        n_out_g++;
      end
      if (g_ivalid && g_oready) q_g.push_back(ref_mul(g_a, g_b, 8, 7, g_rm));
    end
  end

  // Single op through an empty, flowing fp16 pipe; checks latency and value.
  task automatic dir_h(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [1:0] rm, input logic [15:0] er, input logic [3:0] ef);
    int n;
    h_a = a; h_b = b; h_rm = rm; h_iready = 1'b1; h_ivalid = 1'b1;
    @(posedge clk); #1;
    h_ivalid = 1'b0;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (h_ovalid) begin
        n = i;
        break;
      end
    end
    chk({tag, " latency"}, 32'(n), 32'd3);
    chk({tag, " res"}, 32'(h_res), 32'(er));
    chk({tag, " flags"}, 32'(h_flags), 32'(ef));
    @(posedge clk); #1;
  endtask

  task automatic push_h(input logic [15:0] a, input logic [15:0] b, input logic [1:0] rm);
    logic ok;
    h_a = a; h_b = b; h_rm = rm; h_ivalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (h_oready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("push accepted", 32'(ok), 32'd1);
    @(posedge clk); #1;
    h_ivalid = 1'b0;
  endtask

  initial begin
    logic [15:0] ba[5], bb[5];
    logic [1:0]  brm[5];
    logic [19:0] e1;
    int base, n;

    rst_n = 1'b0;
    h_ivalid = 1'b0; h_iready = 1'b1; h_a = '0; h_b = '0; h_rm = 2'd0;
    g_ivalid = 1'b0; g_iready = 1'b1; g_a = '0; g_b = '0; g_rm = 2'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset fp16 o_valid", 32'(h_ovalid), 32'd0);
    chk("reset fp16 o_res", 32'(h_res), 32'd0);
    chk("reset fp16 o_flags", 32'(h_flags), 32'd0);
    chk("reset fp16 o_ready", 32'(h_oready), 32'd1);
    chk("reset bf16 o_valid", 32'(g_ovalid), 32'd0);
    chk("reset bf16 o_ready", 32'(g_oready), 32'd1);
    @(posedge clk); #1;

    // directed fp16
    dir_h("one x one",      16'h3C00, 16'h3C00, 2'd0, 16'h3C00, 4'b0000);
    dir_h("rne tie-ish",    16'h3C01, 16'h3C01, 2'd0, 16'h3C02, 4'b0001);
    dir_h("rup",            16'h3C01, 16'h3C01, 2'd2, 16'h3C03, 4'b0001);
    dir_h("ovf rne",        16'h7BFF, 16'h4000, 2'd0, 16'h7C00, 4'b0101);
    dir_h("ovf rtz",        16'h7BFF, 16'h4000, 2'd1, 16'h7BFF, 4'b0101);
    dir_h("ovf rdn pos",    16'h7BFF, 16'h4000, 2'd3, 16'h7BFF, 4'b0101);
    dir_h("ovf rdn neg",    16'hFBFF, 16'h4000, 2'd3, 16'hFC00, 4'b0101);
    dir_h("inf x zero",     16'h7C00, 16'h0000, 2'd0, 16'h7E00, 4'b1000);
    dir_h("qnan",           16'h7E00, 16'h3C00, 2'd0, 16'h7E00, 4'b0000);
    dir_h("snan",           16'h7C01, 16'h3C00, 2'd0, 16'h7E00, 4'b1000);
    dir_h("neg inf",        16'hFC00, 16'h4000, 2'd0, 16'hFC00, 4'b0000);
    dir_h("daz",            16'h0001, 16'h7BFF, 2'd0, 16'h0000, 4'b0000);
    dir_h("underflow",      16'h0400, 16'h3800, 2'd0, 16'h0000, 4'b0011);

    // directed bf16
    g_a = 16'h3F80; g_b = 16'h4000; g_rm = 2'd0; g_ivalid = 1'b1;
    @(posedge clk); #1;
    g_ivalid = 1'b0;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (g_ovalid) begin
        n = i;
        break;
      end
    end
    chk("bf16 latency", 32'(n), 32'd3);
    chk("bf16 one x two res", 32'(g_res), 32'h4000);
    chk("bf16 one x two flags", 32'(g_flags), 32'd0);
    @(posedge clk); #1;

    // backpressure: 5 ops with downstream stalled
    for (int k = 0; k < 5; k++) begin
      ba[k] = rand_op(5, 10); bb[k] = rand_op(5, 10); brm[k] = 2'($urandom_range(0, 3));
    end
    e1 = ref_mul(ba[0], bb[0], 5, 10, brm[0]);
    base = n_out_h;
    h_iready = 1'b0;
    for (int k = 0; k < 3; k++) push_h(ba[k], bb[k], brm[k]);
    h_a = ba[3]; h_b = bb[3]; h_rm = brm[3]; h_ivalid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("bp o_ready low", 32'(h_oready), 32'd0);
      chk("bp o_valid held", 32'(h_ovalid), 32'd1);
      chk("bp res held", 32'(h_res), 32'(e1[15:0]));
      chk("bp flags held", 32'(h_flags), 32'(e1[19:16]));
      @(posedge clk); #1;
    end
    h_iready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (h_oready) break;
    end
    @(posedge clk); #1;
    h_ivalid = 1'b0;
    push_h(ba[4], bb[4], brm[4]);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (q_h.size() == 0 && !h_ovalid) break;
    end
    chk("bp results out", 32'(n_out_h - base), 32'd5);
    chk("bp queue empty", 32'(q_h.size()), 32'd0);
    @(posedge clk); #1;

    // reset with three ops in flight
    base = n_out_h;
    h_iready = 1'b0;
    for (int k = 0; k < 3; k++) push_h(rand_op(5, 10), rand_op(5, 10), 2'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst o_valid", 32'(h_ovalid), 32'd0);
    chk("rst o_res", 32'(h_res), 32'd0);
    chk("rst o_flags", 32'(h_flags), 32'd0);
    @(posedge clk); #1;
    h_iready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("rst no stale", 32'(h_ovalid), 32'd0);
      @(posedge clk); #1;
    end
    chk("rst nothing out", 32'(n_out_h - base), 32'd0);

    // random traffic on both widths, all rounding modes, random stalls
    for (int c = 0; c < 800; c++) begin
      h_ivalid = ($urandom_range(0, 3) != 0);
      h_a = rand_op(5, 10); h_b = rand_op(5, 10); h_rm = 2'($urandom_range(0, 3));
      h_iready = ($urandom_range(0, 3) != 0);
      g_ivalid = ($urandom_range(0, 3) != 0);
      g_a = rand_op(8, 7); g_b = rand_op(8, 7); g_rm = 2'($urandom_range(0, 3));
      g_iready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    h_ivalid = 1'b0; g_ivalid = 1'b0;
    h_iready = 1'b1; g_iready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (q_h.size() == 0 && q_g.size() == 0 && !h_ovalid && !g_ovalid) break;
    end
    chk("random fp16 drained", 32'(q_h.size()), 32'd0);
    chk("random bf16 drained", 32'(q_g.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
